// File: rtl/ula_seq_md.sv
// ula_seq_md: registered MIPS ALU with built-in ALU-control decode and an
// iterative shift-add multiplier / restoring divider writing HI/LO.
//
// Handshake: an op is taken on a rising edge where start && ready. A
// single-cycle op (including mfhi/mflo and illegal codes) pulses valid in
// the very next cycle with ready still high, so issue may continue every
// cycle. A mult/div drops ready and raises busy for W+1 cycles; start is
// ignored (not queued) meanwhile, and valid pulses once as ready returns.
// result/zero/illegal hold their value until the next valid pulse.
module ula_seq_md #(
    parameter int W         = 32,
    parameter bit MD_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   aluop,
    input  logic [5:0]   funct,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         illegal,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(W);

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_ADDU  = 6'd33;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SUBU  = 6'd35;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MD_RUN = 2'd1,
        S_MD_FIX = 2'd2
    } state_t;

    // Architectural and control state
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           illegal_q, illegal_d;
    logic           valid_q, valid_d;

    // Latched multiply/divide operation
    logic [2*W-1:0] md_p_q, md_p_d;     // mult: {acc, multiplier}; div: {rem, quotient/dividend}
    logic [W-1:0]   md_b_q, md_b_d;     // mult: multiplicand magnitude; div: divisor magnitude
    logic [W-1:0]   md_a_q, md_a_d;     // raw a, needed for divide-by-zero HI
    logic           md_div_q, md_div_d;
    logic           md_neg_q, md_neg_d;   // negate product / quotient
    logic           md_aneg_q, md_aneg_d; // negate remainder
    logic           md_bz_q, md_bz_d;     // divisor was zero

    // Decode results
    logic [W-1:0]   sc_res;
    logic           sc_ill;
    logic           is_md;
    logic           md_is_div;
    logic           md_signed;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    // Iteration and sign-fix datapath
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;

    // ALU-control decode and the single-cycle result for the current request
    always_comb begin
        sc_res    = '0;
        sc_ill    = 1'b0;
        is_md     = 1'b0;
        md_is_div = 1'b0;
        md_signed = 1'b0;
        case (aluop)
            2'd0: sc_res = a + b;
            2'd1: sc_res = a - b;
            2'd2: begin
                case (funct)
                    F_ADD, F_ADDU: sc_res = a + b;
                    F_SUB, F_SUBU: sc_res = a - b;
                    F_AND:  sc_res = a & b;
                    F_OR:   sc_res = a | b;
                    F_XOR:  sc_res = a ^ b;
                    F_NOR:  sc_res = ~(a | b);
                    F_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLTU: sc_res = {{(W-1){1'b0}}, (a < b)};
                    F_MFHI: begin
                        if (MD_ENABLE) sc_res = hi_q;
                        else           sc_ill = 1'b1;
                    end
                    F_MFLO: begin
                        if (MD_ENABLE) sc_res = lo_q;
                        else           sc_ill = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (MD_ENABLE) begin
                            is_md     = 1'b1;
                            md_is_div = funct[1];
                            md_signed = ~funct[0];
                        end else begin
                            sc_ill = 1'b1;
                        end
                    end
                    default: sc_ill = 1'b1;
                endcase
            end
            default: sc_ill = 1'b1;
        endcase
        if (sc_ill) sc_res = '0;
    end

    assign a_mag = (md_signed && a[W-1]) ? -a : a;
    assign b_mag = (md_signed && b[W-1]) ? -b : b;

    // One multiply step (add multiplicand when the multiplier LSB is set, then
    // shift right) and one restoring divide step (shift in next dividend bit,
    // subtract when it fits). The remainder stays below the divisor, so the
    // difference always fits back into W bits.
    always_comb begin
        mul_sum   = {1'b0, md_p_q[2*W-1:W]} + (md_p_q[0] ? {1'b0, md_b_q} : {(W+1){1'b0}});
        div_shift = {md_p_q[2*W-1:W], md_p_q[W-1]};
        div_ge    = (div_shift >= {1'b0, md_b_q});
        div_diff  = div_shift[W-1:0] - md_b_q;
        prod_fix  = md_neg_q  ? -md_p_q         : md_p_q;
        quot_fix  = md_neg_q  ? -md_p_q[W-1:0]  : md_p_q[W-1:0];
        rem_fix   = md_aneg_q ? -md_p_q[2*W-1:W] : md_p_q[2*W-1:W];
    end

    // Next-state logic for the FSM, HI/LO and the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
        md_p_d    = md_p_q;
        md_b_d    = md_b_q;
        md_a_d    = md_a_q;
        md_div_d  = md_div_q;
        md_neg_d  = md_neg_q;
        md_aneg_d = md_aneg_q;
        md_bz_d   = md_bz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_md) begin
                        state_d   = S_MD_RUN;
                        cnt_d     = '0;
                        md_div_d  = md_is_div;
                        md_neg_d  = md_signed & (a[W-1] ^ b[W-1]);
                        md_aneg_d = md_signed & a[W-1];
                        md_a_d    = a;
                        md_bz_d   = (b == '0);
                        if (md_is_div) begin
                            md_p_d = {{W{1'b0}}, a_mag};
                            md_b_d = b_mag;
                        end else begin
                            md_p_d = {{W{1'b0}}, b_mag};
                            md_b_d = a_mag;
                        end
                    end else begin
                        result_d  = sc_res;
                        zero_d    = (sc_res == '0);
                        illegal_d = sc_ill;
                        valid_d   = 1'b1;
                    end
                end
            end
            S_MD_RUN: begin
                if (md_div_q) begin
                    if (div_ge) md_p_d = {div_diff, md_p_q[W-2:0], 1'b1};
                    else        md_p_d = {div_shift[W-1:0], md_p_q[W-2:0], 1'b0};
                end else begin
                    md_p_d = {mul_sum, md_p_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) state_d = S_MD_FIX;
            end
            S_MD_FIX: begin
                if (md_div_q) begin
                    if (md_bz_q) begin
                        lo_d = '1;
                        hi_d = md_a_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                result_d  = lo_d;
                zero_d    = (lo_d == '0);
                illegal_d = 1'b0;
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any multiply/divide in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            md_p_q    <= '0;
            md_b_q    <= '0;
            md_a_q    <= '0;
            md_div_q  <= 1'b0;
            md_neg_q  <= 1'b0;
            md_aneg_q <= 1'b0;
            md_bz_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            md_p_q    <= md_p_d;
            md_b_q    <= md_b_d;
            md_a_q    <= md_a_d;
            md_div_q  <= md_div_d;
            md_neg_q  <= md_neg_d;
            md_aneg_q <= md_aneg_d;
            md_bz_q   <= md_bz_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign valid     = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ula_seq_md.sv
// Bench for ula_seq_md: directed vectors, a reference model built from plain
// arithmetic (64-bit products, / and %), an expected-result queue, and one
// compare process that checks handshake and results on every cycle.
module tb_ula_seq_md;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start2;
    logic [1:0]    aluop;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic          ready, busy, valid, zero, illegal;
    logic [W-1:0]  result;
    logic [1:0]    state_dbg;
    logic          ready2, busy2, valid2, zero2, illegal2;
    logic [W-1:0]  result2;
    logic [1:0]    state_dbg2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int md_start = 0;
    int md_end = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_ill_q[$];
    int           exp_due_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] last_res;
    logic         last_ill;

    ula_seq_md #(.W(W), .MD_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .ready(ready), .busy(busy), .valid(valid), .result(result),
        .zero(zero), .illegal(illegal), .state_dbg(state_dbg)
    );

    ula_seq_md #(.W(W), .MD_ENABLE(1'b0)) dut_nomd (
        .clk(clk), .reset(reset), .start(start2), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .ready(ready2), .busy(busy2), .valid(valid2), .result(result2),
        .zero(zero2), .illegal(illegal2), .state_dbg(state_dbg2)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of one request; updates the model HI/LO for mult/div.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output logic ill, output bit md);
        logic [63:0] p;
        longint sa, sb, q, r;
        res = '0; ill = 1'b0; md = 1'b0;
        case (op)
            2'd0: res = x + y;
            2'd1: res = x - y;
            2'd2: begin
                case (f)
                    6'd32, 6'd33: res = x + y;
                    6'd34, 6'd35: res = x - y;
                    6'd36: res = x & y;
                    6'd37: res = x | y;
                    6'd38: res = x ^ y;
                    6'd39: res = ~(x | y);
                    6'd42: res = ($signed(x) < $signed(y)) ? 1 : 0;
                    6'd43: res = (x < y) ? 1 : 0;
                    6'd16: res = m_hi;
                    6'd18: res = m_lo;
                    6'd24: begin
                        p = longint'($signed(x)) * longint'($signed(y));
                        m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1;
                    end
                    6'd25: begin
                        p = {32'd0, x} * {32'd0, y};
                        m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1;
                    end
                    6'd26, 6'd27: begin
                        md = 1'b1;
                        if (y == 0) begin
                            m_lo = '1; m_hi = x;
                        end else begin
                            if (f == 6'd26) begin
                                sa = longint'($signed(x)); sb = longint'($signed(y));
                            end else begin
                                sa = longint'({32'd0, x}); sb = longint'({32'd0, y});
                            end
                            q = sa / sb; r = sa % sb;
                            p = q; m_lo = p[31:0];
                            p = r; m_hi = p[31:0];
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (md) res = m_lo;
        if (ill) res = '0;
    endfunction

    // Drive a request for one cycle; record its expectation if it will be accepted.
    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic il;
        bit md;
        @(negedge clk);
        aluop = op; funct = f; a = x; b = y; start = 1'b1;
        if (!((cyc >= md_start) && (cyc < md_end))) begin
            model(op, f, x, y, r, il, md);
            exp_q.push_back(r);
            exp_ill_q.push_back(il);
            if (md) begin
                exp_due_q.push_back(cyc + W + 2);
                md_start = cyc + 1;
                md_end   = cyc + W + 2;
            end else begin
                exp_due_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            start2 = 1'b0;
        end
        #1;
    endtask

    // scoreboard: handshake every cycle, results on every valid pulse
    always @(negedge clk) begin : cmp_p
        logic eb;
        logic [W-1:0] r;
        logic il;
        int due;
        if (reset === 1'b0) begin
            eb = (cyc >= md_start) && (cyc < md_end);
            chk("busy", busy, eb);
            chk("ready", ready, !eb);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", valid, 1'b0);
                end else begin
                    due = exp_due_q.pop_front();
                    r   = exp_q.pop_front();
                    il  = exp_ill_q.pop_front();
                    chk("valid_cycle", cyc, due);
                    chk("result", result, r);
                    chk("zero", zero, (r == 0));
                    chk("illegal", illegal, il);
                    last_res = result;
                    last_ill = illegal;
                end
            end else if (exp_q.size() != 0 && exp_due_q[0] <= cyc) begin
                chk("missing_valid", valid, 1'b1);
                void'(exp_due_q.pop_front());
                void'(exp_q.pop_front());
                void'(exp_ill_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        aluop = '0; funct = '0; a = '0; b = '0;
        last_res = '0; last_ill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_valid", valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_state", state_dbg, 0);
        @(posedge clk); #2 reset = 1'b0;

        // single-cycle ops
        issue(2, 32, 7, 5);            idle(1); chk("add_lit", last_res, 12);
        issue(2, 34, 9, 9);            idle(1); chk("sub_lit", last_res, 0);
        issue(2, 42, 32'hFFFFFFFF, 1); idle(1); chk("slt_lit", last_res, 1);
        issue(2, 43, 32'hFFFFFFFF, 1); idle(1); chk("sltu_lit", last_res, 0);

        // back-to-back issue, one per cycle
        issue(2, 36, 32'hF0F0_1234, 32'h0FF0_FFFF);
        issue(2, 37, 32'hF000_0000, 32'h0000_000F);
        issue(2, 38, 32'hAAAA_AAAA, 32'hFFFF_0000);
        issue(2, 39, 32'h1234_0000, 32'h0000_5678);
        issue(2, 33, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(2, 35, 32'h0000_0001, 32'h0000_0002);
        issue(0, 6'd0, 32'd100, 32'd23);
        issue(1, 6'd0, 32'd5, 32'd5);
        idle(1); chk("beq_sub_lit", last_res, 0);

        // HI/LO clear after reset
        issue(2, 16, 0, 0); idle(1); chk("mfhi_rst_lit", last_res, 0);
        issue(2, 18, 0, 0); idle(1); chk("mflo_rst_lit", last_res, 0);

        // multiply
        issue(2, 24, -32'sd3, 32'd7); idle(W + 2);
        chk("mult_lo_lit", last_res, 32'hFFFF_FFEB);
        chk("mult_model_hi", m_hi, 32'hFFFF_FFFF);
        issue(2, 16, 0, 0); idle(1); chk("mult_hi_lit", last_res, 32'hFFFF_FFFF);
        issue(2, 25, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(W + 2);
        chk("multu_lo_lit", last_res, 1);
        issue(2, 16, 0, 0); idle(1); chk("multu_hi_lit", last_res, 32'hFFFF_FFFE);

        // divide
        issue(2, 26, -32'sd7, 32'd2); idle(W + 2);
        chk("div_lo_lit", last_res, 32'hFFFF_FFFD);
        issue(2, 16, 0, 0); idle(1); chk("div_hi_lit", last_res, 32'hFFFF_FFFF);

        // divu by zero with start held and operands changing while busy
        issue(2, 27, -32'sd7, 32'd0);
        for (int i = 0; i < W; i++)
            issue(2, 6'($urandom_range(32, 43)), $urandom, $urandom);
        idle(2);
        chk("divu0_lo_lit", last_res, 32'hFFFF_FFFF);
        issue(2, 16, 0, 0); idle(1); chk("divu0_hi_lit", last_res, 32'hFFFF_FFF9);

        issue(2, 26, 32'h8000_0000, 32'hFFFF_FFFF); idle(W + 2);
        chk("div_ovf_lo_lit", last_res, 32'h8000_0000);
        issue(2, 16, 0, 0); idle(1); chk("div_ovf_hi_lit", last_res, 0);

        issue(2, 26, 32'd7, -32'sd2); idle(W + 2);
        chk("div_negb_lo_lit", last_res, 32'hFFFF_FFFD);
        issue(2, 16, 0, 0); idle(1); chk("div_negb_hi_lit", last_res, 1);

        issue(2, 27, 32'd100, 32'd7); idle(W + 2);
        chk("divu_lo_lit", last_res, 14);
        issue(2, 16, 0, 0); idle(1); chk("divu_hi_lit", last_res, 2);

        issue(2, 26, -32'sd7, 32'd0); idle(W + 2);
        chk("div0_lo_lit", last_res, 32'hFFFF_FFFF);

        // illegal codes leave HI/LO alone
        issue(3, 6'd32, 5, 5); idle(1);
        chk("ill_aluop_res", last_res, 0); chk("ill_aluop_flag", last_ill, 1);
        issue(2, 6'd0, 5, 5); idle(1);
        chk("ill_funct_res", last_res, 0); chk("ill_funct_flag", last_ill, 1);
        issue(2, 16, 0, 0); idle(1); chk("div0_hi_lit", last_res, 32'hFFFF_FFF9);

        // reset in the middle of a multiply
        issue(2, 24, -32'sd3, 32'd7); idle(9);
        @(posedge clk); #2;
        reset = 1'b1;
        exp_q.delete(); exp_ill_q.delete(); exp_due_q.delete();
        m_hi = '0; m_lo = '0; md_start = 0; md_end = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        chk("abort_state", state_dbg, 0);
        @(posedge clk); #2 reset = 1'b0;
        idle(W + 4);
        issue(2, 16, 0, 0); idle(1); chk("abort_hi_lit", last_res, 0);
        issue(2, 18, 0, 0); idle(1); chk("abort_lo_lit", last_res, 0);

        // instance without multiply/divide
        @(negedge clk);
        aluop = 2; funct = 6'd24; a = 32'd3; b = 32'd7; start2 = 1'b1;
        idle(1);
        chk("nomd_valid", valid2, 1);
        chk("nomd_illegal", illegal2, 1);
        chk("nomd_result", result2, 0);
        chk("nomd_zero", zero2, 1);
        chk("nomd_ready", ready2, 1);
        chk("nomd_busy", busy2, 0);
        chk("nomd_state", state_dbg2, 0);
        @(negedge clk);
        aluop = 2; funct = 6'd32; a = 32'd3; b = 32'd7; start2 = 1'b1;
        idle(1);
        chk("nomd_add", result2, 10);
        chk("nomd_add_ill", illegal2, 0);

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
